// File: rtl/manchester_rx_display_if.sv
// Line-side and display-side signals of the Manchester receiver/display driver.
// master = line/button source, slave = receiver driving the display patterns.
interface manchester_rx_display_if;
    logic       mline;
    logic       bright_step;
    logic [7:0] led8;
    logic [7:0] H_digi;
    logic [7:0] L_digi;
    logic [2:0] ld1;
    logic [2:0] ld2;
    logic [1:0] state_select;
    logic       cs;

    modport master (
        output mline, bright_step,
        input  led8, H_digi, L_digi, ld1, ld2, state_select, cs
    );

    modport slave (
        input  mline, bright_step,
        output led8, H_digi, L_digi, ld1, ld2, state_select, cs
    );
endinterface

// File: rtl/manchester_rx_display.sv
// Manchester byte-frame receiver with parity check, producing raw LED bar,
// seven-segment, RGB status and brightness-select patterns for the dimmer.
module manchester_rx_display #(
    parameter int unsigned OSR = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    manchester_rx_display_if.slave  bus
);

    localparam int unsigned CW = $clog2(5 * OSR / 4 + 1);
    localparam logic [CW-1:0] CNT_LO = CW'(3 * OSR / 4);
    localparam logic [CW-1:0] CNT_HI = CW'(5 * OSR / 4);

    typedef enum logic [1:0] {IDLE, RECV, STOP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic [8:0]     sr_q, sr_d;
    logic           sync1_q, ms_q, ms_prev_q;
    logic           ms_edge;
    logic           frame_ok, frame_err;

    logic [7:0]     led8_q, h_digi_q, l_digi_q;
    logic [2:0]     ld1_q, ld2_q;
    logic [1:0]     state_select_q;
    logic           cs_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign ms_edge = ms_q ^ ms_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            ms_q      <= 1'b0;
            ms_prev_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            sr_q      <= '0;
        end else begin
            sync1_q   <= bus.mline;
            ms_q      <= sync1_q;
            ms_prev_q <= ms_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            sr_q      <= sr_d;
        end
    end

    // cnt measures cycles since the last accepted mid-bit edge; anything
    // earlier than 3/4 of a bit is a boundary transition or a glitch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        sr_d      = sr_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (ms_q && !ms_prev_q) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (ms_edge && cnt_q >= CNT_LO) begin
                    sr_d     = {sr_q[7:0], ms_q};
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd8) begin
                        state_d = STOP;
                    end
                end else if (cnt_q == CNT_HI) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LO) begin
                    state_d = IDLE;
                    if (ms_q || (^sr_q)) begin
                        frame_err = 1'b1;
                    end else begin
                        frame_ok = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led8_q         <= 8'hFF;
            h_digi_q       <= '0;
            l_digi_q       <= '0;
            ld1_q          <= 3'b111;
            ld2_q          <= 3'b111;
            state_select_q <= 2'b11;
            cs_q           <= 1'b0;
        end else begin
            cs_q  <= 1'b1;
            ld1_q <= (state_d == IDLE) ? 3'b111 : 3'b110;
            if (frame_ok) begin
                led8_q   <= ~sr_q[8:1];
                h_digi_q <= {1'b0, seg7(sr_q[8:5])};
                l_digi_q <= {1'b0, seg7(sr_q[4:1])};
                ld2_q    <= 3'b101;
            end else if (frame_err) begin
                h_digi_q[7] <= 1'b1;
                ld2_q       <= 3'b011;
            end
            if (bus.bright_step) begin
                case (state_select_q)
                    2'b01:   state_select_q <= 2'b00;
                    2'b00:   state_select_q <= 2'b10;
                    2'b10:   state_select_q <= 2'b11;
                    default: state_select_q <= 2'b01;
                endcase
            end
        end
    end

    assign bus.led8         = led8_q;
    assign bus.H_digi       = h_digi_q;
    assign bus.L_digi       = l_digi_q;
    assign bus.ld1          = ld1_q;
    assign bus.ld2          = ld2_q;
    assign bus.state_select = state_select_q;
    assign bus.cs           = cs_q;

endmodule

// File: tb/tb_manchester_rx_display.sv
// Randomized bench for manchester_rx_display against a frame-level reference model.
module tb_manchester_rx_display;

    localparam int unsigned OSR = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    manchester_rx_display_if bus();

    manchester_rx_display #(.OSR(OSR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [1:0] LEVEL [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

    logic [7:0]  exp_led, exp_h, exp_l;
    logic [2:0]  exp_ld2;
    int unsigned bidx;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_led = 8'hFF;
        exp_h   = 8'h00;
        exp_l   = 8'h00;
        exp_ld2 = 3'b111;
        bidx    = 3;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic p, input bit complete);
        if (!complete || ($countones({d, p}) % 2) != 0) begin
            exp_ld2  = 3'b011;
            exp_h[7] = 1'b1;
        end else begin
            exp_led = ~d;
            exp_h   = SEG[d[7:4]];
            exp_l   = SEG[d[3:0]];
            exp_ld2 = 3'b101;
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_cs);
        check({tag, ".led8"}, bus.led8, exp_led);
        check({tag, ".H"}, bus.H_digi, exp_h);
        check({tag, ".L"}, bus.L_digi, exp_l);
        check({tag, ".ld1"}, bus.ld1, 3'b111);
        check({tag, ".ld2"}, bus.ld2, exp_ld2);
        check({tag, ".sel"}, bus.state_select, LEVEL[bidx]);
        check({tag, ".cs"}, bus.cs, exp_cs);
    endtask

    task automatic drive(input logic v, input int n);
        bus.mline = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic bright_pulse();
        bus.bright_step = 1'b1;
        @(negedge clk);
        bus.bright_step = 1'b0;
        bidx = (bidx + 1) % 4;
        check("bright", bus.state_select, LEVEL[bidx]);
    endtask

    // Drives start + data + parity; with nbits < 10 the line is frozen at the
    // last mid-bit level. t_mid is the cycle stamp of the last mid-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input int nbits,
                              input bit jit, input bit glt, output int unsigned t_mid);
        logic [9:0] bits;
        bits  = {1'b1, d, p};
        t_mid = 0;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            int   hb1;
            b   = bits[9-i];
            hb1 = jit ? 5 + int'($urandom_range(6)) : int'(OSR / 2);
            if (i == 1) check("ld1_busy", bus.ld1, 3'b110);
            drive(~b, hb1);
            bus.mline = b;
            t_mid = cyc;
            if (i == nbits - 1 && nbits < 10) return;
            if (glt) begin
                repeat (5) @(negedge clk);
                drive(~b, 1);
                drive(b, 2);
            end else begin
                repeat (OSR / 2) @(negedge clk);
            end
        end
        bus.mline = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic p,
                             input bit jit, input bit glt, input bit step_at_result);
        int unsigned t;
        send_frame(d, p, 10, jit, glt, t);
        if (step_at_result) begin
            while (cyc < t + 15) @(negedge clk);
            bus.bright_step = 1'b1;
            @(negedge clk);
            bus.bright_step = 1'b0;
            bidx = (bidx + 1) % 4;
        end
        for (int g = 0; g < 64 && bus.ld1 !== 3'b111; g++) @(negedge clk);
        check({tag, ".latency"}, cyc - t, 16);
        model_frame(d, p, 1'b1);
        check_outputs(tag, 1'b1);
        repeat (OSR) @(negedge clk);
    endtask

    initial begin
        int unsigned t;
        logic [7:0]  d;
        logic        p;

        bus.mline = 1'b0;
        bus.bright_step = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cs_after_reset", bus.cs, 1'b1);

        for (int i = 0; i < 4; i++) bright_pulse();
        repeat (OSR) @(negedge clk);

        run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("3c_bad", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

        d = 8'($urandom);
        send_frame(d, 1'b0, 5, 1'b0, 1'b0, t);
        while (cyc < t + 23) @(negedge clk);
        check("frm.ld1_pre", bus.ld1, 3'b110);
        check("frm.ld2_pre", bus.ld2, exp_ld2);
        @(negedge clk);
        model_frame(d, 1'b0, 1'b0);
        check_outputs("frm", 1'b1);
        bus.mline = 1'b0;
        repeat (2 * OSR) @(negedge clk);

        run_frame("5a_glitch", 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            p = ^d;
            if ($urandom_range(3) == 0) p = ~p;
            run_frame("rand", d, p, 1'($urandom), 1'($urandom), $urandom_range(3) == 0);
            if ($urandom_range(1) == 1) bright_pulse();
        end

        d = 8'($urandom);
        send_frame(d, 1'b1, 5, 1'b0, 1'b0, t);
        rst_n = 1'b0;
        bus.mline = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs("midreset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset.cs", bus.cs, 1'b1);
        repeat (OSR) @(negedge clk);
        d = 8'($urandom);
        run_frame("after_reset", d, ^d, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
